// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller for a 64x8 dual-port RAM.
// Port A writes, port B reads; the RAM's registered q_b is the output data.
module ram_fifo_ctrl #(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic [AW-1:0] ram_addr_a,
    output logic [DW-1:0] ram_data_a,
    output logic          ram_we_a,
    output logic [AW-1:0] ram_addr_b,
    output logic          ram_we_b,
    input  logic [DW-1:0] ram_q_b
);

    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    logic [AW:0]   wr_ptr_q,    wr_ptr_d;
    logic [AW:0]   fetch_ptr_q, fetch_ptr_d;
    logic [AW:0]   head_ptr_q,  head_ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] addr_b_q,    addr_b_d;

    logic [AW:0]   level;
    logic          can_push;
    logic          push;
    logic          pop;
    logic          fetch;

    // Occupancy comes from registered pointers only, so a pop frees space
    // one cycle later rather than creating a ready->valid combinational path.
    always_comb begin
        level    = wr_ptr_q - head_ptr_q;
        can_push = (level != FULL);
        push     = in_valid && can_push;
        pop      = out_valid_q && out_ready;
        fetch    = (fetch_ptr_q != wr_ptr_q) && (!out_valid_q || out_ready);
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fetch_ptr_d = fetch_ptr_q;
        head_ptr_d  = head_ptr_q;
        out_valid_d = out_valid_q;
        addr_b_d    = addr_b_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            head_ptr_d = head_ptr_q + 1'b1;
        end
        // A fetch lands in q_b on the next edge, which is exactly when the
        // displayed word is either replaced or the register was empty.
        if (fetch) begin
            fetch_ptr_d = fetch_ptr_q + 1'b1;
            addr_b_d    = fetch_ptr_q[AW-1:0];
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            fetch_ptr_q <= '0;
            head_ptr_q  <= '0;
            out_valid_q <= 1'b0;
            addr_b_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fetch_ptr_q <= fetch_ptr_d;
            head_ptr_q  <= head_ptr_d;
            out_valid_q <= out_valid_d;
            addr_b_q    <= addr_b_d;
        end
    end

    // Holding the last fetched address keeps q_b, and so out_data, stable
    // while the consumer stalls.
    always_comb begin
        in_ready   = can_push;
        count      = level;
        out_valid  = out_valid_q;
        out_data   = ram_q_b;
        ram_we_a   = push;
        ram_addr_a = wr_ptr_q[AW-1:0];
        ram_data_a = in_data;
        ram_we_b   = 1'b0;
        ram_addr_b = fetch ? fetch_ptr_q[AW-1:0] : addr_b_q;
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM plus a queue-based reference model.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] count;
    logic [5:0] ram_addr_a;
    logic [7:0] ram_data_a;
    logic       ram_we_a;
    logic [5:0] ram_addr_b;
    logic       ram_we_b;
    logic [7:0] ram_q_b;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] q[$];
    int         wcnt = 0;
    int         gap = 0;
    logic [5:0] prev_a = '0;
    logic [5:0] prev_b = '0;
    logic       wrap_a = 1'b0;
    logic       wrap_b = 1'b0;

    ram_fifo_ctrl #(.DW(8), .AW(6)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count),
        .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a),
        .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b)
    );

    always #5 clk = ~clk;

    // 64x8 RAM with registered port-B read
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // then advance the model by the transfers that happen at the next edge.
    task automatic cyc(input logic iv, input logic [7:0] id, input logic ordy);
        logic full_m;
        logic push_m;
        logic pop_m;
        @(negedge clk);
        in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        full_m = (q.size() == 64);
        push_m = iv && !full_m;
        pop_m  = out_valid && ordy;
        chk("count", 32'(count), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(!full_m));
        chk("we_a", 32'(ram_we_a), 32'(push_m));
        if (ram_we_a) begin
            chk("addr_a", 32'(ram_addr_a), 32'(wcnt % 64));
            chk("data_a", 32'(ram_data_a), 32'(id));
            if (ram_addr_a == 6'd0 && prev_a == 6'd63) wrap_a = 1'b1;
            prev_a = ram_addr_a;
        end
        if (ram_addr_b == 6'd0 && prev_b == 6'd63) wrap_b = 1'b1;
        prev_b = ram_addr_b;
        if (out_valid) begin
            if (q.size() == 0) chk("valid_when_empty", 32'(out_valid), 32'd0);
            else chk("out_data", 32'(out_data), 32'(q[0]));
        end
        if (!out_valid && q.size() > 0) gap++;
        else gap = 0;
        chk("gap_le2", 32'(gap <= 2), 32'd1);
        chk("no_collide", 32'(ram_we_a && out_valid && ram_addr_a == ram_addr_b), 32'd0);
        if (pop_m && q.size() > 0) void'(q.pop_front());
        if (push_m) begin
            q.push_back(id);
            wcnt++;
        end
    endtask

    task automatic reset_model();
        q.delete();
        wcnt = 0;
        gap = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_addr_b", 32'(ram_addr_b), 32'd0);
        chk("rst_we_a", 32'(ram_we_a), 32'd0);
        chk("rst_we_b", 32'(ram_we_b), 32'd0);
        reset_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // first word latency
        do_reset();
        cyc(1'b1, 8'h11, 1'b0);
        chk("first_addr_a", 32'(ram_addr_a), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("lat_k1_vld", 32'(out_valid), 32'd0);
        chk("lat_k1_we", 32'(ram_we_a), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("lat_k2_vld", 32'(out_valid), 32'd1);
        chk("lat_k2_data", 32'(out_data), 32'h11);
        chk("lat_k2_count", 32'(count), 32'd1);

        // push/pop together at count 1
        cyc(1'b1, 8'h5A, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("c1_k1_vld", 32'(out_valid), 32'd0);
        chk("c1_k1_count", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("c1_k2_vld", 32'(out_valid), 32'd1);
        chk("c1_k2_data", 32'(out_data), 32'h5A);

        // fill to 64 with consumer stalled
        do_reset();
        for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b1, 8'hEE, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd64);
        chk("full_head", 32'(out_data), 32'h00);

        // pop while full: push refused, room appears next cycle
        cyc(1'b1, 8'hEE, 1'b1);
        chk("fullpop_we", 32'(ram_we_a), 32'd0);
        cyc(1'b1, 8'h40, 1'b0);
        chk("after_pop_ready", 32'(in_ready), 32'd1);

        // drain 64 back-to-back
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("drain_vld", 32'(out_valid), 32'd1);
        end
        cyc(1'b0, 8'h00, 1'b0);
        chk("drained_vld", 32'(out_valid), 32'd0);
        chk("drained_count", 32'(count), 32'd0);

        // streaming across the address wrap
        wrap_a = 1'b0; wrap_b = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 8'($urandom), 1'b1);
            if (i >= 2) chk("wrap_vld", 32'(out_valid), 32'd1);
        end
        chk("wrap_addr_a", 32'(wrap_a), 32'd1);
        chk("wrap_addr_b", 32'(wrap_b), 32'd1);
        repeat (4) cyc(1'b0, 8'h00, 1'b1);

        // random traffic
        repeat (2000) cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        repeat (70) cyc(1'b0, 8'h00, 1'b1);
        chk("rand_empty", 32'(count), 32'd0);

        // asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("pre_rst_vld", 32'(out_valid), 32'd1);
        chk("pre_rst_count", 32'(count), 32'd10);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_vld", 32'(out_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 8'hA5, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("post_rst_k1", 32'(out_valid), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("post_rst_k2_vld", 32'(out_valid), 32'd1);
        chk("post_rst_k2_data", 32'(out_data), 32'hA5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
